// File: rtl/uart_loader.sv
// UART 8N1 receiver plus header/payload framing that streams a program image
// into the inst_memory load port and releases the CPU with load_done.
module uart_loader #(
  parameter int CLK_PER_BIT    = 868,
  parameter int INST_MEM_WIDTH = 2,
  parameter int HOLD_CYCLES    = 4
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] loader_data,
  output logic       loader_ready,
  output logic       loader_enable,
  output logic       load_done,
  output logic       frame_err,
  output logic       overflow,
  output logic [1:0] dbg_rx_state,
  output logic [1:0] dbg_frm_state
);

  // Handshake: loader_ready is a one-cycle strobe with no backpressure;
  // loader_data is valid in the strobe cycle and held until the next strobe.

  localparam int CW = $clog2(CLK_PER_BIT);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [32:0] N_LIMIT = 33'(1) << INST_MEM_WIDTH;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {F_HDR, F_LOAD, F_HOLD} frm_state_t;

  rx_state_t  rx_st, rx_next;
  frm_state_t frm_st, frm_next;

  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          brk;
  logic          byte_valid, stop_err;
  logic          bit_end, half_end;

  logic [1:0]    hdr_idx;
  logic [23:0]   hdr_word;
  logic [31:0]   n_word;
  logic [33:0]   rem;
  logic [HW-1:0] hold_cnt;

  assign bit_end       = (cnt == CW'(CLK_PER_BIT - 1));
  assign half_end      = (cnt == CW'(CLK_PER_BIT / 2 - 1));
  assign n_word        = {hdr_word, shreg};
  assign dbg_rx_state  = rx_st;
  assign dbg_frm_state = frm_st;

  // Synchroniser resets to the idle-high level so reset release is not an edge.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    rx_next    = rx_st;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    case (rx_st)
      R_IDLE:  if (rx_prev && !rx_sync) rx_next = R_START;
      R_START: if (half_end) rx_next = rx_sync ? R_IDLE : R_DATA;
      R_DATA:  if (bit_end && bit_idx == 3'd7) rx_next = R_STOP;
      R_STOP: begin
        // After a bad stop bit, park here until the line returns high.
        if (brk) begin
          if (rx_sync) rx_next = R_IDLE;
        end else if (bit_end) begin
          if (rx_sync) begin
            byte_valid = 1'b1;
            rx_next    = R_IDLE;
          end else begin
            stop_err = 1'b1;
          end
        end
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      rx_st   <= R_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      brk     <= 1'b0;
    end else begin
      rx_st <= rx_next;
      if (rx_next != rx_st || rx_st == R_IDLE || bit_end) cnt <= '0;
      else                                                 cnt <= cnt + CW'(1);
      if (rx_st == R_DATA && bit_end) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (stop_err)              brk <= 1'b1;
      else if (rx_next == R_IDLE) brk <= 1'b0;
    end
  end

  always_comb begin
    frm_next = frm_st;
    case (frm_st)
      F_HDR:  if (byte_valid && hdr_idx == 2'd3 && n_word != 32'd0) frm_next = F_LOAD;
      F_LOAD: begin
        if (stop_err)                        frm_next = F_HDR;
        else if (byte_valid && rem == 34'd1) frm_next = F_HOLD;
      end
      F_HOLD: if (hold_cnt == HW'(HOLD_CYCLES - 1)) frm_next = F_HDR;
      default: frm_next = F_HDR;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      frm_st        <= F_HDR;
      hdr_idx       <= '0;
      hdr_word      <= '0;
      rem           <= '0;
      hold_cnt      <= '0;
      loader_data   <= '0;
      loader_ready  <= 1'b0;
      loader_enable <= 1'b0;
      load_done     <= 1'b0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      frm_st       <= frm_next;
      loader_ready <= 1'b0;
      load_done    <= 1'b0;
      if (stop_err) frame_err <= 1'b1;
      case (frm_st)
        F_HDR: begin
          if (stop_err) begin
            hdr_idx <= '0;
          end else if (byte_valid) begin
            hdr_word <= n_word[23:0];
            hdr_idx  <= hdr_idx + 2'd1;
            if (hdr_idx == 2'd3) begin
              if (n_word == 32'd0) begin
                load_done <= 1'b1;
              end else begin
                loader_enable <= 1'b1;
                rem           <= {n_word, 2'b00};
                if ({1'b0, n_word} > N_LIMIT) overflow <= 1'b1;
              end
            end
          end
        end
        F_LOAD: begin
          if (stop_err) begin
            loader_enable <= 1'b0;
            hdr_idx       <= '0;
          end else if (byte_valid) begin
            loader_data  <= shreg;
            loader_ready <= 1'b1;
            rem          <= rem - 34'd1;
            hold_cnt     <= '0;
          end
        end
        F_HOLD: begin
          hold_cnt <= hold_cnt + HW'(1);
          if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
            loader_enable <= 1'b0;
            load_done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: serial driver tasks, a negedge monitor with
// an expected-byte queue, and a final summary.
module tb_uart_loader;

  localparam int CPB   = 16;
  localparam int FRAME = 10 * CPB;

  logic       CLK = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] loader_data;
  logic       loader_ready, loader_enable, load_done, frame_err, overflow;
  logic [1:0] dbg_rx_state, dbg_frm_state;

  uart_loader #(.CLK_PER_BIT(CPB), .INST_MEM_WIDTH(2), .HOLD_CYCLES(4)) dut (
    .CLK(CLK), .reset(reset), .rx(rx),
    .loader_data(loader_data), .loader_ready(loader_ready),
    .loader_enable(loader_enable), .load_done(load_done),
    .frame_err(frame_err), .overflow(overflow),
    .dbg_rx_state(dbg_rx_state), .dbg_frm_state(dbg_frm_state)
  );

  // clock / cycle counter
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc++;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard / monitor
  logic [7:0] exp_q[$];
  int ready_cyc[$];
  int done_cnt = 0, done_cyc = 0;
  int en_rise_cnt = 0, en_rise_cyc = 0, en_fall_cnt = 0, en_fall_cyc = 0;
  logic en_prev = 1'b0;

  always @(negedge CLK) begin
    if (loader_ready) begin
      logic [31:0] exp;
      ready_cyc.push_back(cyc);
      exp = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h100;
      check_eq("ready_data", 32'(loader_data), exp);
      check_eq("ready_in_enable", 32'(loader_enable), 32'd1);
    end
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (loader_enable && !en_prev) begin
      en_rise_cnt++;
      en_rise_cyc = cyc;
    end
    if (!loader_enable && en_prev) begin
      en_fall_cnt++;
      en_fall_cyc = cyc;
    end
    en_prev = loader_enable;
  end

  function automatic int first_rdy();
    return (ready_cyc.size() > 0) ? ready_cyc[0] : -100000;
  endfunction

  function automatic int last_rdy();
    return (ready_cyc.size() > 0) ? ready_cyc[ready_cyc.size()-1] : -100000;
  endfunction

  // driver tasks
  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic send_hdr(input logic [31:0] n);
    for (int i = 3; i >= 0; i--) send_byte(n[8*i +: 8], 1'b1);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send_payload(input logic [7:0] b);
    exp_q.push_back(b);
    send_byte(b, 1'b1);
  endtask

  int base_done, base_rise, base_fall, min_gap;
  logic [7:0] t1_bytes [4];
  logic [7:0] t5_bytes [4];

  initial begin
    t1_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    t5_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("reset_outputs", 32'({loader_data, loader_ready, loader_enable, load_done, frame_err, overflow}), 32'd0);
    check_eq("reset_fsm", 32'({dbg_rx_state, dbg_frm_state}), 32'd0);
    reset = 1'b1;
    idle(5);

    // 1: N=1, one big-endian word
    ready_cyc.delete();
    base_done = done_cnt; base_rise = en_rise_cnt;
    send_hdr(32'd1);
    foreach (t1_bytes[i]) send_payload(t1_bytes[i]);
    idle(20);
    check_eq("t1_ready_count", 32'(ready_cyc.size()), 32'd4);
    check_eq("t1_en_rise", 32'(en_rise_cnt - base_rise), 32'd1);
    check_eq("t1_en_lead", 32'(first_rdy() - en_rise_cyc), 32'(FRAME));
    check_eq("t1_en_fall_gap", 32'(en_fall_cyc - last_rdy()), 32'd4);
    check_eq("t1_done_at_fall", 32'(done_cyc), 32'(en_fall_cyc));
    check_eq("t1_done_count", 32'(done_cnt - base_done), 32'd1);
    check_eq("t1_overflow", 32'(overflow), 32'd0);
    check_eq("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // 2: N=0
    base_done = done_cnt; base_rise = en_rise_cnt;
    send_hdr(32'd0);
    idle(20);
    check_eq("t2_done_count", 32'(done_cnt - base_done), 32'd1);
    check_eq("t2_no_enable", 32'(en_rise_cnt - base_rise), 32'd0);

    // 3: false start
    ready_cyc.delete();
    rx = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    idle(40);
    check_eq("t3_no_ready", 32'(ready_cyc.size()), 32'd0);
    check_eq("t3_rx_idle", 32'(dbg_rx_state), 32'd0);
    check_eq("t3_frm_hdr", 32'(dbg_frm_state), 32'd0);

    // 4: stop-bit error mid payload
    ready_cyc.delete();
    base_done = done_cnt;
    send_hdr(32'd1);
    send_payload(8'hAA);
    check_eq("t4_en_before_err", 32'(loader_enable), 32'd1);
    check_eq("t4_no_err_yet", 32'(frame_err), 32'd0);
    send_byte(8'h55, 1'b0);
    idle(20);
    check_eq("t4_frame_err", 32'(frame_err), 32'd1);
    check_eq("t4_en_dropped", 32'(loader_enable), 32'd0);
    check_eq("t4_frm_hdr", 32'(dbg_frm_state), 32'd0);
    check_eq("t4_no_done", 32'(done_cnt - base_done), 32'd0);
    check_eq("t4_ready_count", 32'(ready_cyc.size()), 32'd1);
    send_hdr(32'd0);
    idle(20);
    check_eq("t4_done_after_err", 32'(done_cnt - base_done), 32'd1);

    // 5: asynchronous reset mid payload
    send_hdr(32'd1);
    send_payload(8'hDE);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    check_eq("t5_pre_reset", 32'({loader_enable, frame_err}), 32'h3);
    #3;
    reset = 1'b0;
    #1;
    check_eq("t5_async_clear", 32'({loader_data, loader_ready, loader_enable, load_done, frame_err, overflow}), 32'd0);
    rx = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    reset = 1'b1;
    idle(10);
    check_eq("t5_q_empty", 32'(exp_q.size()), 32'd0);
    ready_cyc.delete();
    base_done = done_cnt;
    send_hdr(32'd1);
    foreach (t5_bytes[i]) send_payload(t5_bytes[i]);
    idle(20);
    check_eq("t5_ready_count", 32'(ready_cyc.size()), 32'd4);
    check_eq("t5_done_count", 32'(done_cnt - base_done), 32'd1);
    check_eq("t5_frame_err", 32'(frame_err), 32'd0);

    // 6: N=5 exceeds 4-word memory
    ready_cyc.delete();
    base_done = done_cnt; base_rise = en_rise_cnt; base_fall = en_fall_cnt;
    send_hdr(32'd5);
    check_eq("t6_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 20; i++) send_payload(8'(i * 11 + 3));
    idle(20);
    check_eq("t6_ready_count", 32'(ready_cyc.size()), 32'd20);
    check_eq("t6_en_rise", 32'(en_rise_cnt - base_rise), 32'd1);
    check_eq("t6_en_fall", 32'(en_fall_cnt - base_fall), 32'd1);
    check_eq("t6_en_fall_gap", 32'(en_fall_cyc - last_rdy()), 32'd4);
    check_eq("t6_done_count", 32'(done_cnt - base_done), 32'd1);
    min_gap = 100000;
    for (int i = 1; i < ready_cyc.size(); i++)
      if (ready_cyc[i] - ready_cyc[i-1] < min_gap) min_gap = ready_cyc[i] - ready_cyc[i-1];
    check_eq("t6_ready_spacing", 32'(min_gap), 32'(FRAME));
    check_eq("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
